// File: rtl/uart_tx_byte_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_byte_if : byte/strobe handshake between the word splitter and the
//                   UART transmitter.                          rev 1.0
// ---------------------------------------------------------------------------
interface uart_tx_byte_if;
  logic [7:0] din;
  logic       TXen;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output din, output TXen, input tx, input busy, input done);
  modport slave  (input din, input TXen, output tx, output busy, output done);
endinterface
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_byte : sends one byte per rising TXen edge as a UART frame
//                (start, 8 data LSB first, optional parity, 1/2 stop).  rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           RST,
  uart_tx_byte_if.slave  bus
);

  localparam int             CNT_W     = 9;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             txen_d;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic             done_r;
  logic             start;
  logic             cnt_last;
  logic             tx_c;
  logic             busy_c;

  assign start    = bus.TXen & ~txen_d;
  assign cnt_last = (state == S_STOP) ? (cnt == STOP_LAST) : (cnt == BIT_LAST);

  // State register plus datapath; txen_d resets high so a strobe already
  // asserted at reset release is not mistaken for a new byte.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      txen_d  <= 1'b1;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
      bit_idx <= 3'd0;
      cnt     <= '0;
      done_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      txen_d <= bus.TXen;
      done_r <= (state == S_STOP) && cnt_last;
      if (state == S_IDLE) begin
        cnt     <= '0;
        bit_idx <= 3'd0;
        if (start) begin
          shreg   <= bus.din;
          par_bit <= (PARITY == 2) ? ~(^bus.din) : (^bus.din);
        end
      end else begin
        cnt <= cnt_last ? '0 : cnt + 1'b1;
        if ((state == S_DATA) && cnt_last)
          bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_START;
      S_START: if (cnt_last) state_nxt = S_DATA;
      S_DATA:  if (cnt_last && (bit_idx == 3'd7))
                 state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (cnt_last) state_nxt = S_STOP;
      S_STOP:  if (cnt_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_c   = 1'b1;
    busy_c = (state != S_IDLE);
    case (state)
      S_START: tx_c = 1'b0;
      S_DATA:  tx_c = shreg[bit_idx];
      S_PAR:   tx_c = par_bit;
      default: tx_c = 1'b1;
    endcase
  end

  assign bus.tx   = tx_c;
  assign bus.busy = busy_c;
  assign bus.done = done_r;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_byte.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_byte : four transmitter configurations driven in parallel and
//                   compared every cycle against a frame-table model.  rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_byte;

  logic       clk;
  logic       rst;
  logic       txen;
  logic [7:0] din;

  int total = 0;
  int bad   = 0;

  uart_tx_byte_if bus0 ();
  uart_tx_byte_if bus1 ();
  uart_tx_byte_if bus2 ();
  uart_tx_byte_if bus3 ();

  assign bus0.din = din;  assign bus0.TXen = txen;
  assign bus1.din = din;  assign bus1.TXen = txen;
  assign bus2.din = din;  assign bus2.TXen = txen;
  assign bus3.din = din;  assign bus3.TXen = txen;

  uart_tx_byte #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .RST(rst), .bus(bus0));
  uart_tx_byte #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (.clk(clk), .RST(rst), .bus(bus1));
  uart_tx_byte #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (.clk(clk), .RST(rst), .bus(bus2));
  uart_tx_byte #(.CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(2)) u3 (.clk(clk), .RST(rst), .bus(bus3));

  logic [3:0] tx_v, busy_v, done_v;
  assign tx_v   = {bus3.tx,   bus2.tx,   bus1.tx,   bus0.tx};
  assign busy_v = {bus3.busy, bus2.busy, bus1.busy, bus0.busy};
  assign done_v = {bus3.done, bus2.done, bus1.done, bus0.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each accepted byte becomes a table of frame bits; the
  // line value is looked up by how many edges have passed since acceptance.
  int   n_c[4]    = '{4, 4, 4, 2};
  int   par_c[4]  = '{0, 1, 2, 0};
  int   stop_c[4] = '{1, 1, 1, 2};
  logic mact[4];
  int   mpos[4];
  logic mbits[4][12];
  logic mprev;

  function automatic int frame_len(input int i);
    return 9 + ((par_c[i] != 0) ? 1 : 0) + stop_c[i];
  endfunction

  function automatic logic exp_busy(input int i);
    return mact[i] && (mpos[i] < frame_len(i) * n_c[i]);
  endfunction

  function automatic logic exp_done(input int i);
    return mact[i] && (mpos[i] == frame_len(i) * n_c[i]);
  endfunction

  function automatic logic exp_tx(input int i);
    return exp_busy(i) ? mbits[i][mpos[i] / n_c[i]] : 1'b1;
  endfunction

  task automatic model_reset();
    mprev = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mact[i] = 1'b0;
      mpos[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic st;
    if (rst) begin
      model_reset();
      return;
    end
    st    = txen && !mprev;
    mprev = txen;
    for (int i = 0; i < 4; i++) begin
      if ((!mact[i] || mpos[i] >= frame_len(i) * n_c[i]) && st) begin
        mact[i] = 1'b1;
        mpos[i] = 0;
        for (int b = 0; b < 12; b++) mbits[i][b] = 1'b1;
        mbits[i][0] = 1'b0;
        for (int b = 0; b < 8; b++) mbits[i][1 + b] = din[b];
        if (par_c[i] == 1) mbits[i][9] = ^din;
        if (par_c[i] == 2) mbits[i][9] = ~(^din);
      end else if (mact[i]) begin
        mpos[i] = mpos[i] + 1;
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, expv);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("tx%0d", i),   {31'd0, tx_v[i]},   {31'd0, exp_tx(i)});
      check_val($sformatf("busy%0d", i), {31'd0, busy_v[i]}, {31'd0, exp_busy(i)});
      check_val($sformatf("done%0d", i), {31'd0, done_v[i]}, {31'd0, exp_done(i)});
    end
  endtask

  // One cycle: check what the previous edge produced, then set up the next.
  task automatic step(input logic t, input logic [7:0] d, input logic r);
    @(negedge clk);
    compare_all();
    txen = t;
    din  = d;
    rst  = r;
    model_edge();
  endtask

  initial begin
    int guard;
    rst  = 1'b1;
    txen = 1'b0;
    din  = 8'h00;
    model_reset();

    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b0, 8'h00, 1'b0);

    // Basic 0xA5 frame, then 0x01 for the even-parity odd-ones case
    step(1'b1, 8'hA5, 1'b0);
    for (int k = 0; k < 50; k++) step(1'b0, 8'hA5, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 50; k++) step(1'b0, 8'h01, 1'b0);

    // Strobe held high across the frame, then a fresh edge with new data
    for (int k = 0; k < 200; k++) step(1'b1, 8'h3C, 1'b0);
    for (int k = 0; k < 2; k++)   step(1'b0, 8'h3C, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    for (int k = 0; k < 50; k++) step(1'b0, 8'($urandom), 1'b0);

    // Edges and data changes mid-frame must be ignored
    step(1'b1, 8'h5A, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 8'h5A, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    for (int k = 0; k < 50; k++) step(1'b0, 8'hFF, 1'b0);

    // Asynchronous reset during data bit 3 of configuration 0
    step(1'b1, 8'h96, 1'b0);
    guard = 0;
    while (!(mact[0] && mpos[0] / n_c[0] == 4) && guard < 100) begin
      step(1'b0, 8'h96, 1'b0);
      guard++;
    end
    check_val("reach_bit3", {31'd0, (guard < 100)}, 32'd1);
    @(negedge clk);
    compare_all();
    #2 rst = 1'b1;
    txen = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("rst_tx%0d", i),   {31'd0, tx_v[i]},   32'd1);
      check_val($sformatf("rst_busy%0d", i), {31'd0, busy_v[i]}, 32'd0);
    end
    step(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    for (int k = 0; k < 50; k++) step(1'b0, 8'h22, 1'b0);

    // Back-to-back on the two-stop-bit unit: re-strobe right after done
    for (int k = 0; k < 150; k++) step(exp_done(3), 8'($urandom), 1'b0);

    // Random strobes and data
    for (int k = 0; k < 2500; k++)
      step(($urandom % 4) == 0, 8'($urandom), 1'b0);

    @(negedge clk);
    compare_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
